instruction_cache: RTL and testbench

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache_pkg.sv | 45 ++++
 rtl/instruction_cache.sv | 116 +++++++++++
 tb/tb_instruction_cache.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_pkg.sv
// ============================================================================
// Module : instruction_cache_pkg
// Shared cache constants, FSM encoding and the block word-select helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instruction_cache_pkg;

    localparam int TAG_W     = 3;
    localparam int INDEX_W   = 3;
    localparam int OFFSET_W  = 2;
    localparam int BLOCK_W   = 128;
    localparam int WORD_W    = 32;
    localparam int NUM_LINES = 1 << INDEX_W;

    // Data-cache geometry shares the same line organisation.
    localparam int DCACHE_TAG_W    = 3;
    localparam int DCACHE_INDEX_W  = 3;
    localparam int DCACHE_OFFSET_W = 2;
    localparam int DCACHE_BLOCK_W  = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } cache_state_e;

    function automatic logic [WORD_W-1:0] block_word(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        logic [WORD_W-1:0] w;
        case (off)
            2'd0:    w = blk[31:0];
            2'd1:    w = blk[63:32];
            2'd2:    w = blk[95:64];
            default: w = blk[127:96];
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_cache.sv
// ============================================================================
// Module : instruction_cache
// Direct-mapped 8-line read-only cache with single-block refill from memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int MISS_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_read,
    input  logic [9:0]            cpu_address,
    output logic [WORD_W-1:0]     cpu_instruction,
    output logic                  cpu_busywait,
    output logic                  mem_read,
    output logic [5:0]            mem_address,
    input  logic [BLOCK_W-1:0]    mem_readinst,
    input  logic                  mem_busywait,
    output logic [MISS_CNT_W-1:0] miss_count
);

    cache_state_e                state_q, state_d;
    logic [NUM_LINES-1:0]        valid_q, valid_d;
    logic [MISS_CNT_W-1:0]       miss_q, miss_d;
    logic [TAG_W-1:0]            tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]          data_q [NUM_LINES];

    logic [TAG_W-1:0]            addr_tag;
    logic [INDEX_W-1:0]          addr_index;
    logic [OFFSET_W-1:0]         addr_offset;
    logic                        hit;
    logic                        fill_en;
    logic                        miss_event;
    logic                        unused_byte_bits;

    assign addr_tag         = cpu_address[9:7];
    assign addr_index       = cpu_address[6:4];
    assign addr_offset      = cpu_address[3:2];
    assign unused_byte_bits = ^cpu_address[1:0];

    assign hit = cpu_read & valid_q[addr_index] & (tag_q[addr_index] == addr_tag);

    assign cpu_instruction = hit ? block_word(data_q[addr_index], addr_offset) : '0;
    assign miss_count      = miss_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        miss_d       = miss_q;
        mem_read     = 1'b0;
        mem_address  = '0;
        cpu_busywait = 1'b0;
        fill_en      = 1'b0;
        miss_event   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_read && !hit) begin
                    cpu_busywait = 1'b1;
                    miss_event   = 1'b1;
                    state_d      = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read     = 1'b1;
                mem_address  = {addr_tag, addr_index};
                cpu_busywait = 1'b1;
                if (!mem_busywait) begin
                    fill_en             = 1'b1;
                    valid_d[addr_index] = 1'b1;
                    state_d             = UPDATE;
                end
            end
            UPDATE: begin
                cpu_busywait = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (miss_event && (miss_q != '1)) begin
            miss_d = miss_q + MISS_CNT_W'(1);
        end

        // The stall must drop the instant reset asserts, even with cpu_read held.
        if (!reset_n) begin
            cpu_busywait = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_q[addr_index] <= mem_readinst;
            tag_q[addr_index]  <= addr_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_cache.sv
// ============================================================================
// Module : tb_instruction_cache
// Directed self-checking bench for instruction_cache with a behavioural memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_cache;

    logic         clock;
    logic         reset_n;
    logic         cpu_read;
    logic [9:0]   cpu_address;
    logic [31:0]  cpu_instruction;
    logic         cpu_busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;
    logic [15:0]  miss_count;

    logic [31:0]  s_instruction;
    logic         s_busywait;
    logic         s_mem_read;
    logic [5:0]   s_mem_address;
    logic [3:0]   s_miss_count;

    int           n_checks;
    int           n_pass;
    int           mem_lat;
    int           wait_cnt;

    instruction_cache #(.MISS_CNT_W(16)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cpu_read        (cpu_read),
        .cpu_address     (cpu_address),
        .cpu_instruction (cpu_instruction),
        .cpu_busywait    (cpu_busywait),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_readinst    (mem_readinst),
        .mem_busywait    (mem_busywait),
        .miss_count      (miss_count)
    );

    // Narrow-counter copy runs in lockstep to reach saturation quickly.
    instruction_cache #(.MISS_CNT_W(4)) dut_sat (
        .clock           (clock),
        .reset_n         (reset_n),
        .cpu_read        (cpu_read),
        .cpu_address     (cpu_address),
        .cpu_instruction (s_instruction),
        .cpu_busywait    (s_busywait),
        .mem_read        (s_mem_read),
        .mem_address     (s_mem_address),
        .mem_readinst    (mem_readinst),
        .mem_busywait    (mem_busywait),
        .miss_count      (s_miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word w of block A reads 0xC0DE_0000 | A<<8 | w.
    function automatic logic [127:0] mk_block(input logic [5:0] a);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[32*w +: 32] = {16'hC0DE, 2'b00, a, 6'b000000, 2'(w)};
        end
        return b;
    endfunction

    assign mem_readinst = mk_block(mem_address);
    assign mem_busywait = mem_read && (wait_cnt < mem_lat);

    always @(posedge clock) begin
        if (!mem_read) wait_cnt <= 0;
        else           wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_hit();
        int n;
        n = 0;
        while (cpu_busywait && n < 50) begin
            tick();
            n++;
        end
        check_eq("hit_wait_busy", 32'(cpu_busywait), 32'd0);
    endtask

    task automatic idle_cycle();
        cpu_read = 1'b0;
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        mem_lat     = 2;
        wait_cnt    = 0;
        reset_n     = 1'b0;
        cpu_read    = 1'b1;
        cpu_address = 10'h000;
        #1;
        check_eq("rst_busy",   32'(cpu_busywait), 32'd0);
        check_eq("rst_memrd",  32'(mem_read), 32'd0);
        check_eq("rst_maddr",  32'(mem_address), 32'd0);
        check_eq("rst_instr",  cpu_instruction, 32'd0);
        check_eq("rst_miss",   32'(miss_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Cold miss at 0x000
        #1;
        check_eq("cold_busy",   32'(cpu_busywait), 32'd1);
        check_eq("cold_idle_memrd", 32'(mem_read), 32'd0);
        tick();
        check_eq("cold_memrd",  32'(mem_read), 32'd1);
        check_eq("cold_maddr",  32'(mem_address), 32'h00);
        check_eq("cold_miss",   32'(miss_count), 32'd1);
        wait_hit();
        check_eq("cold_instr",  cpu_instruction, 32'hC0DE0000);
        check_eq("cold_miss2",  32'(miss_count), 32'd1);

        // Same-block hit, no stall
        cpu_address = 10'h004;
        #1;
        check_eq("hit_busy",    32'(cpu_busywait), 32'd0);
        check_eq("hit_instr",   cpu_instruction, 32'hC0DE0001);
        check_eq("hit_memrd",   32'(mem_read), 32'd0);
        tick();
        check_eq("hit_memrd2",  32'(mem_read), 32'd0);
        check_eq("hit_miss",    32'(miss_count), 32'd1);

        // Conflict miss at 0x080 then 0x000 misses again
        cpu_address = 10'h080;
        #1;
        check_eq("conf_busy",   32'(cpu_busywait), 32'd1);
        check_eq("conf_instr0", cpu_instruction, 32'd0);
        tick();
        check_eq("conf_maddr",  32'(mem_address), 32'h08);
        wait_hit();
        check_eq("conf_instr",  cpu_instruction, 32'hC0DE0800);
        check_eq("conf_miss",   32'(miss_count), 32'd2);
        cpu_address = 10'h000;
        #1;
        check_eq("rem_busy",    32'(cpu_busywait), 32'd1);
        wait_hit();
        check_eq("rem_instr",   cpu_instruction, 32'hC0DE0000);
        check_eq("rem_miss",    32'(miss_count), 32'd3);
        idle_cycle();

        // Reset pulsed mid-refill
        cpu_read    = 1'b1;
        cpu_address = 10'h010;
        tick();
        check_eq("mr_memrd",    32'(mem_read), 32'd1);
        check_eq("mr_maddr",    32'(mem_address), 32'h01);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mr_rst_memrd", 32'(mem_read), 32'd0);
        check_eq("mr_rst_busy",  32'(cpu_busywait), 32'd0);
        check_eq("mr_rst_miss",  32'(miss_count), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check_eq("mr_again_busy", 32'(cpu_busywait), 32'd1);
        wait_hit();
        check_eq("mr_instr",    cpu_instruction, 32'hC0DE0100);
        check_eq("mr_miss",     32'(miss_count), 32'd1);
        idle_cycle();

        // cpu_read dropped during the refill
        cpu_read    = 1'b1;
        cpu_address = 10'h024;
        tick();
        check_eq("drop_memrd",  32'(mem_read), 32'd1);
        cpu_read = 1'b0;
        begin
            int n;
            n = 0;
            while (mem_read && n < 50) begin
                tick();
                n++;
            end
        end
        check_eq("drop_done",   32'(mem_read), 32'd0);
        tick();
        check_eq("drop_busy",   32'(cpu_busywait), 32'd0);
        check_eq("drop_instr",  cpu_instruction, 32'd0);
        check_eq("drop_miss",   32'(miss_count), 32'd2);
        tick();
        cpu_read = 1'b1;
        #1;
        check_eq("drop_hit_busy",  32'(cpu_busywait), 32'd0);
        check_eq("drop_hit_instr", cpu_instruction, 32'hC0DE0201);
        idle_cycle();

        // Alternating conflict misses drive the narrow counter to saturation
        mem_lat = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_read    = 1'b1;
            cpu_address = (i % 2 == 0) ? 10'h040 : 10'h0C0;
            #1;
            wait_hit();
            if (i == 12) begin
                check_eq("sat_at_max",   32'(s_miss_count), 32'hF);
                check_eq("wide_at_15",   32'(miss_count), 32'd15);
            end
        end
        check_eq("sat_hold",    32'(s_miss_count), 32'hF);
        check_eq("wide_22",     32'(miss_count), 32'd22);
        check_eq("sat_instr",   cpu_instruction, 32'hC0DE0C00);
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
